// File: rtl/sdram_ctrl_sched.sv
// SDRAM command-state scheduler: init sequence, work FSM with round-robin read/write,
// postponable refresh debt and runtime mode-register reload.
//
// state   | meaning
// I_NOP   | power-up wait
// I_PRE   | init precharge-all
// I_TRP   | precharge wait
// I_AR    | init auto-refresh
// I_TRF   | auto-refresh wait
// I_MRS   | init mode-register set
// I_TMRD  | mode-register wait
// I_DONE  | init complete, work FSM enabled
// W_IDLE  | arbitration point
// W_ACTIVE/W_TRCD           | row activate and wait
// W_READ/W_CL/W_RD          | read command, CAS latency, read data
// W_WRITE/W_WD/W_TWR        | write command, write data, recovery
// W_PRE/W_TRP               | precharge and wait
// W_AR/W_TRFC, W_MRS/W_TMRD | refresh, mode reload
module sdram_ctrl_sched #(
    parameter int PWRUP_CYC    = 20000,
    parameter int TRP          = 4,
    parameter int TRFC         = 6,
    parameter int TMRD         = 6,
    parameter int TRCD         = 2,
    parameter int TCL          = 3,
    parameter int TWR          = 2,
    parameter int INIT_AR_NUM  = 8,
    parameter int REF_INTERVAL = 781,
    parameter int REF_DEBT_MAX = 4,
    parameter int BURST_W      = 10,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sdram_wr_req,
    input  logic               sdram_rd_req,
    input  logic               sdram_mrs_req,
    input  logic [BURST_W-1:0] sdram_wr_burst,
    input  logic [BURST_W-1:0] sdram_rd_burst,
    output logic               sdram_wr_ack,
    output logic               sdram_rd_ack,
    output logic               sdram_mrs_ack,
    output logic               sdram_init_done,
    output logic [2:0]         init_state,
    output logic [3:0]         work_state,
    output logic [CNT_W-1:0]   cnt_clk,
    output logic               sdram_rd_wr,
    output logic [2:0]         ref_debt
);
    typedef enum logic [2:0] {
        I_NOP = 3'd0, I_PRE = 3'd1, I_TRP = 3'd2, I_AR = 3'd3,
        I_TRF = 3'd4, I_MRS = 3'd5, I_TMRD = 3'd6, I_DONE = 3'd7
    } init_t;

    typedef enum logic [3:0] {
        W_IDLE = 4'd0, W_ACTIVE = 4'd1, W_TRCD = 4'd2, W_READ = 4'd3, W_CL = 4'd4,
        W_RD = 4'd5, W_WRITE = 4'd6, W_WD = 4'd7, W_TWR = 4'd8, W_PRE = 4'd9,
        W_TRP = 4'd10, W_AR = 4'd11, W_TRFC = 4'd12, W_MRS = 4'd13, W_TMRD = 4'd14
    } work_t;

    localparam logic [CNT_W-1:0] PWRUP_END = CNT_W'(((PWRUP_CYC > 1) ? PWRUP_CYC : 1) - 1);
    localparam logic [CNT_W-1:0] TRP_END   = CNT_W'(((TRP  > 1) ? TRP  : 1) - 1);
    localparam logic [CNT_W-1:0] TRFC_END  = CNT_W'(((TRFC > 1) ? TRFC : 1) - 1);
    localparam logic [CNT_W-1:0] TMRD_END  = CNT_W'(((TMRD > 1) ? TMRD : 1) - 1);
    localparam logic [CNT_W-1:0] TRCD_END  = CNT_W'(((TRCD > 1) ? TRCD : 1) - 1);
    localparam logic [CNT_W-1:0] TCL_END   = CNT_W'(((TCL  > 1) ? TCL  : 1) - 1);
    localparam logic [CNT_W-1:0] TWR_END   = CNT_W'(((TWR  > 1) ? TWR  : 1) - 1);
    localparam logic [7:0]       AR_NUM    = 8'(INIT_AR_NUM);
    localparam int               REF_W     = $clog2(REF_INTERVAL + 1);
    localparam logic [REF_W-1:0] REF_END   = REF_W'(REF_INTERVAL - 1);
    localparam logic [2:0]       DEBT_MAX  = 3'(REF_DEBT_MAX);
    localparam logic [2:0]       DEBT_SAT  = 3'(REF_DEBT_MAX + 2);

    init_t              init_q, init_d;
    work_t              work_q, work_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         ar_cnt;
    logic [BURST_W-1:0] burst_q;
    logic               is_rd_q;
    logic               rd_wr_q;
    logic               rr_wr_q;
    logic [REF_W-1:0]   ref_cnt;
    logic [2:0]         debt_q;
    logic [CNT_W-1:0]   burst_end;
    logic               sel_rd;
    logic               take;
    logic               tick;
    logic               ar_entry;

    assign burst_end = CNT_W'(burst_q) - CNT_W'(1);
    assign tick      = (ref_cnt == REF_END);
    assign ar_entry  = (work_q == W_IDLE) && (work_d == W_AR);
    // Round-robin only matters when both requests are present; rr_wr_q=1 means write wins.
    assign sel_rd    = (sdram_wr_req && sdram_rd_req) ? ~rr_wr_q : sdram_rd_req;

    always_comb begin
        init_d = init_q;
        case (init_q)
            I_NOP:   if (cnt_q == PWRUP_END) init_d = I_PRE;
            I_PRE:   init_d = I_TRP;
            I_TRP:   if (cnt_q == TRP_END) init_d = I_AR;
            I_AR:    init_d = I_TRF;
            I_TRF:   if (cnt_q == TRFC_END) init_d = (ar_cnt >= AR_NUM) ? I_MRS : I_AR;
            I_MRS:   init_d = I_TMRD;
            I_TMRD:  if (cnt_q == TMRD_END) init_d = I_DONE;
            I_DONE:  init_d = I_DONE;
            default: init_d = I_NOP;
        endcase
    end

    always_comb begin
        work_d = work_q;
        take   = 1'b0;
        case (work_q)
            W_IDLE: begin
                if (init_q == I_DONE) begin
                    if (debt_q >= DEBT_MAX)                  work_d = W_AR;
                    else if (sdram_mrs_req)                  work_d = W_MRS;
                    else if (sdram_wr_req || sdram_rd_req) begin
                        work_d = W_ACTIVE;
                        take   = 1'b1;
                    end
                    else if (debt_q != 3'd0)                 work_d = W_AR;
                end
            end
            W_ACTIVE: work_d = W_TRCD;
            W_TRCD:   if (cnt_q == TRCD_END) work_d = is_rd_q ? W_READ : W_WRITE;
            W_READ:   work_d = W_CL;
            W_CL:     if (cnt_q == TCL_END) work_d = W_RD;
            W_RD:     if (cnt_q == burst_end) work_d = W_PRE;
            W_WRITE:  work_d = W_WD;
            W_WD:     if (cnt_q == burst_end) work_d = W_TWR;
            W_TWR:    if (cnt_q == TWR_END) work_d = W_PRE;
            W_PRE:    work_d = W_TRP;
            W_TRP:    if (cnt_q == TRP_END) work_d = W_IDLE;
            W_AR:     work_d = W_TRFC;
            W_TRFC:   if (cnt_q == TRFC_END) work_d = W_IDLE;
            W_MRS:    work_d = W_TMRD;
            W_TMRD:   if (cnt_q == TMRD_END) work_d = W_IDLE;
            default:  work_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_q  <= I_NOP;
            work_q  <= W_IDLE;
            cnt_q   <= '0;
            ar_cnt  <= '0;
            burst_q <= BURST_W'(1);
            is_rd_q <= 1'b1;
            rd_wr_q <= 1'b1;
            rr_wr_q <= 1'b1;
            ref_cnt <= '0;
            debt_q  <= '0;
        end else begin
            init_q <= init_d;
            work_q <= work_d;
            cnt_q  <= ((init_d != init_q) || (work_d != work_q)) ? '0 : cnt_q + CNT_W'(1);
            if (init_q == I_AR) ar_cnt <= ar_cnt + 8'd1;
            if (take) begin
                if (sel_rd) burst_q <= (sdram_rd_burst == '0) ? BURST_W'(1) : sdram_rd_burst;
                else        burst_q <= (sdram_wr_burst == '0) ? BURST_W'(1) : sdram_wr_burst;
                is_rd_q <= sel_rd;
                rd_wr_q <= sel_rd;
                if (sdram_wr_req && sdram_rd_req) rr_wr_q <= ~rr_wr_q;
            end else if (work_d == W_IDLE) begin
                rd_wr_q <= 1'b1;
            end
            ref_cnt <= tick ? '0 : ref_cnt + REF_W'(1);
            // A tick coinciding with a refresh entry cancels out.
            if (tick && !ar_entry && (debt_q != DEBT_SAT)) debt_q <= debt_q + 3'd1;
            else if (!tick && ar_entry)                    debt_q <= debt_q - 3'd1;
        end
    end

    assign init_state      = init_q;
    assign work_state      = work_q;
    assign cnt_clk         = cnt_q;
    assign sdram_rd_wr     = rd_wr_q;
    assign ref_debt        = debt_q;
    assign sdram_init_done = (init_q == I_DONE);
    assign sdram_wr_ack    = (work_q == W_WD);
    assign sdram_rd_ack    = (work_q == W_RD);
    assign sdram_mrs_ack   = (work_q == W_MRS);
endmodule
